// File: rtl/uart_rx_cfg_if.sv
// Word handshake between uart_rx_cfg (master) and the downstream packet parser (slave).
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_frame_err,
        output rx_parity_err,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_frame_err,
        input  rx_parity_err,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted sampling, framing/parity/break detection,
// and a first-word-fall-through output FIFO.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rxd,
    uart_rx_cfg_if.master     rx,
    output logic              overflow,
    output logic              break_det,
    output logic              busy
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int M            = BAUD_CNT_MAX / 2;
    localparam int CW           = $clog2(BAUD_CNT_MAX);
    localparam int BW           = $clog2(DATA_BITS + 1);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int WW           = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2, S_BRK
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [1:0]           samp_q, samp_d;
    logic                 sync1_q, sync2_q, hist_q;
    logic                 overflow_q, brk_q, brk_d;
    logic                 push, maj, dec;

    logic [WW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_q, rd_q;
    logic                 empty, full, pop, wr_en;
    logic [WW-1:0]        head, push_word;

    // Idle-high reset values keep reset release from looking like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
    assign dec = (cnt_q == CNT_DEC);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        samp_d    = samp_q;
        push      = 1'b0;
        brk_d     = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
        if (cnt_q == CNT_S0) samp_d[0] = sync2_q;
        if (cnt_q == CNT_S1) samp_d[1] = sync2_q;

        unique case (state_q)
            S_IDLE: begin
                if (hist_q && !sync2_q) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_bit_d = 1'b0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            S_START: begin
                if (dec) state_d = maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (dec) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) state_d = (PARITY == 0) ? S_STOP1 : S_PAR;
                end
            end
            S_PAR: begin
                if (dec) begin
                    par_bit_d = maj;
                    par_err_d = (PARITY == 1) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
                    state_d   = S_STOP1;
                end
            end
            S_STOP1: begin
                if (dec) begin
                    if (!maj && (shift_q == '0) && !par_bit_q) begin
                        brk_d   = 1'b1;
                        state_d = S_BRK;
                    end else begin
                        frm_err_d = ~maj;
                        if (STOP_BITS == 2) begin
                            state_d = S_STOP2;
                        end else begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_STOP2: begin
                if (dec) begin
                    frm_err_d = frm_err_q | ~maj;
                    push      = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_BRK: begin
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign push_word = {par_err_d, frm_err_d, shift_q};
    assign empty     = (wr_q == rd_q);
    assign full      = ((wr_q - rd_q) == (AW + 1)'(FIFO_DEPTH));
    assign pop       = !empty && rx.rx_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en     = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            samp_q     <= 2'b11;
            overflow_q <= 1'b0;
            brk_q      <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            samp_q     <= samp_d;
            overflow_q <= push && full && !pop;
            brk_q      <= brk_d;
            if (wr_en) wr_q <= wr_q + (AW + 1)'(1);
            if (pop)   rd_q <= rd_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= push_word;
    end

    assign head             = mem[rd_q[AW-1:0]];
    assign rx.rx_valid      = !empty;
    assign rx.rx_data       = empty ? '0 : head[DATA_BITS-1:0];
    assign rx.rx_frame_err  = empty ? 1'b0 : head[DATA_BITS];
    assign rx.rx_parity_err = empty ? 1'b0 : head[DATA_BITS+1];
    assign overflow         = overflow_q;
    assign break_det        = brk_q;
    assign busy             = (state_q != S_IDLE);
endmodule
